// File: rtl/spike_rate_encoder_if.sv
// Load/step/spike bus of the rate encoder. The bench or controller drives the master
// side and the encoder is the slave.
//
// Handshake: a load transfers on a rising clk edge where load_valid && load_ready
// are both high. load_valid may be held and is ignored while load_ready is low.
// step/abort are single-cycle strobes with no ready. spike_valid/done are one-cycle
// pulses with no back-pressure.
interface spike_rate_encoder_if #(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_W     = 8,
  parameter int WINDOW_W   = 8
);
  logic                         load_valid;
  logic                         load_ready;
  logic [NUM_INPUTS*DATA_W-1:0] intensity;
  logic [WINDOW_W-1:0]          window_len;
  logic                         step;
  logic                         abort;
  logic [NUM_INPUTS-1:0]        spike_out;
  logic                         spike_valid;
  logic                         busy;
  logic                         done;
  logic [1:0]                   fsm_state;  // 0 IDLE, 1 RUN, 2 DONE

  modport master (
    output load_valid, intensity, window_len, step, abort,
    input  load_ready, spike_out, spike_valid, busy, done, fsm_state
  );

  modport slave (
    input  load_valid, intensity, window_len, step, abort,
    output load_ready, spike_out, spike_valid, busy, done, fsm_state
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Rate-coding spike generator. Each channel has a phase accumulator. A spike is the
// accumulator carry, so channel i fires at intensity/2^DATA_W per accepted step.
module spike_rate_encoder #(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_W     = 8,
  parameter int WINDOW_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spike_rate_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  logic [NUM_INPUTS*DATA_W-1:0] int_q;
  logic [NUM_INPUTS*DATA_W-1:0] acc_q;
  logic [NUM_INPUTS*DATA_W-1:0] acc_next;
  logic [NUM_INPUTS-1:0]        carry;
  logic [WINDOW_W-1:0]          win_q;
  logic [WINDOW_W-1:0]          step_cnt;
  logic                         load_ready_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         spike_valid_q;
  logic [NUM_INPUTS-1:0]        spike_q;

  // The widened sum keeps the carry, which is the spike for this step.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    logic [DATA_W:0] sum;
    assign sum = {1'b0, acc_q[i*DATA_W +: DATA_W]} + {1'b0, int_q[i*DATA_W +: DATA_W]};
    assign acc_next[i*DATA_W +: DATA_W] = sum[DATA_W-1:0];
    assign carry[i] = sum[DATA_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      int_q         <= '0;
      win_q         <= '0;
      acc_q         <= '0;
      step_cnt      <= '0;
      load_ready_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_q       <= '0;
    end else begin
      spike_valid_q <= 1'b0;
      spike_q       <= '0;
      done_q        <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid && load_ready_q) begin
            int_q        <= bus.intensity;
            win_q        <= bus.window_len;
            acc_q        <= '0;
            step_cnt     <= '0;
            load_ready_q <= 1'b0;
            // A zero-length window skips RUN and only reports completion.
            if (bus.window_len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
            acc_q        <= '0;
            step_cnt     <= '0;
          end else if (bus.step) begin
            acc_q         <= acc_next;
            spike_q       <= carry;
            spike_valid_q <= 1'b1;
            step_cnt      <= step_cnt + 1'b1;
            // win_q is non-zero here, so this compare never underflows.
            if (step_cnt == win_q - 1'b1) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          load_ready_q <= 1'b1;
          if (bus.abort) begin
            acc_q    <= '0;
            step_cnt <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          load_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_out   = spike_q;
  assign bus.fsm_state   = state;

endmodule
